// File: rtl/button_event_pkg.sv
// button_event_pkg: shared definitions for the button event generator.
//   state_e    per-channel FSM state encoding (2'd3 is illegal, recovers to StIdle)
//   cnt_width  counter width for a given hold/repeat configuration
package button_event_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StHold   = 2'd1,
    StRepeat = 2'd2
  } state_e;

  // clog2 of the larger interval, never less than one bit.
  function automatic int unsigned cnt_width(int unsigned hold_cycles,
                                            int unsigned repeat_cycles);
    int unsigned max_cycles;
    int unsigned width;
    max_cycles = (hold_cycles > repeat_cycles) ? hold_cycles : repeat_cycles;
    width      = $clog2(max_cycles);
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/button_event_channel.sv
// button_event_channel: one button's press / auto-repeat FSM with its interval counter.
// Optional feature macro: BUTTON_EVENT_RELEASE_EN (adds o_release).
// Ports:
//   i_clk      system clock, posedge
//   i_rst      asynchronous active-high reset
//   i_in       debounced, clk-synchronous level (1 = pressed)
//   o_press    one-cycle pulse on press
//   o_repeat   one-cycle pulse per auto-repeat tick
//   o_event    o_press | o_repeat, registered in the same stage
//   o_held     1 while the FSM is in StHold or StRepeat
//   o_release  (BUTTON_EVENT_RELEASE_EN only) one-cycle pulse on release
module button_event_channel
  import button_event_pkg::*;
#(
  parameter int unsigned HoldCycles   = 50000000,
  parameter int unsigned RepeatCycles = 10000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_in,
  output logic o_press,
  output logic o_repeat,
  output logic o_event,
  output logic o_held
`ifdef BUTTON_EVENT_RELEASE_EN
  ,
  output logic o_release
`endif
);

  localparam int unsigned CntW = cnt_width(HoldCycles, RepeatCycles);
  localparam logic [CntW-1:0] HoldLast   = CntW'(HoldCycles - 1);
  localparam logic [CntW-1:0] RepeatLast = CntW'(RepeatCycles - 1);

  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic            r_press;
  logic            r_repeat;
  logic            r_event;
  logic            r_held;
  logic [CntW-1:0] w_cnt_last;

  assign w_cnt_last = (r_state == StHold) ? HoldLast : RepeatLast;

  // StIdle doubles as the "previous level was low" memory, so a level that is
  // still high when reset drops yields a fresh press on the first edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_press  <= 1'b0;
      r_repeat <= 1'b0;
      r_event  <= 1'b0;
      r_held   <= 1'b0;
`ifdef BUTTON_EVENT_RELEASE_EN
      o_release <= 1'b0;
`endif
    end else begin
      r_press  <= 1'b0;
      r_repeat <= 1'b0;
      r_event  <= 1'b0;
`ifdef BUTTON_EVENT_RELEASE_EN
      o_release <= 1'b0;
`endif
      case (r_state)
        StIdle: begin
          if (i_in) begin
            r_state <= StHold;
            r_cnt   <= '0;
            r_press <= 1'b1;
            r_event <= 1'b1;
            r_held  <= 1'b1;
          end
        end
        StHold, StRepeat: begin
          if (!i_in) begin
            // Release wins over a repeat due on the same edge.
            r_state <= StIdle;
            r_cnt   <= '0;
            r_held  <= 1'b0;
`ifdef BUTTON_EVENT_RELEASE_EN
            o_release <= 1'b1;
`endif
          end else if (r_cnt == w_cnt_last) begin
            r_state  <= StRepeat;
            r_cnt    <= '0;
            r_repeat <= 1'b1;
            r_event  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        default: begin
          r_state <= StIdle;
          r_cnt   <= '0;
          r_held  <= 1'b0;
        end
      endcase
    end
  end

  assign o_press  = r_press;
  assign o_repeat = r_repeat;
  assign o_event  = r_event;
  assign o_held   = r_held;

endmodule

// File: rtl/button_event.sv
// button_event: turns debounced button levels into press / auto-repeat event pulses,
// one independent channel FSM per button.
// Optional feature macro: BUTTON_EVENT_RELEASE_EN (adds o_release).
// Ports:
//   i_clk      system clock, posedge
//   i_rst      asynchronous active-high reset
//   i_in       debounced levels [PortWidth], 1 = pressed
//   o_press    press pulses [PortWidth]
//   o_repeat   auto-repeat pulses [PortWidth]
//   o_event    press | repeat [PortWidth]
//   o_held     channel not idle [PortWidth]
//   o_release  (BUTTON_EVENT_RELEASE_EN only) release pulses [PortWidth]
module button_event
  import button_event_pkg::*;
#(
  parameter int unsigned PortWidth    = 1,
  parameter int unsigned HoldCycles   = 50000000,
  parameter int unsigned RepeatCycles = 10000000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [PortWidth-1:0] i_in,
  output logic [PortWidth-1:0] o_press,
  output logic [PortWidth-1:0] o_repeat,
  output logic [PortWidth-1:0] o_event,
  output logic [PortWidth-1:0] o_held
`ifdef BUTTON_EVENT_RELEASE_EN
  ,
  output logic [PortWidth-1:0] o_release
`endif
);

  if (HoldCycles < 2) begin : g_bad_hold
    $error("button_event: HoldCycles must be >= 2");
  end
  if (RepeatCycles < 1) begin : g_bad_repeat
    $error("button_event: RepeatCycles must be >= 1");
  end

  for (genvar g = 0; g < PortWidth; g++) begin : g_ch
    button_event_channel #(
      .HoldCycles  (HoldCycles),
      .RepeatCycles(RepeatCycles)
    ) u_ch (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_in     (i_in[g]),
      .o_press  (o_press[g]),
      .o_repeat (o_repeat[g]),
      .o_event  (o_event[g]),
      .o_held   (o_held[g])
`ifdef BUTTON_EVENT_RELEASE_EN
      ,
      .o_release(o_release[g])
`endif
    );
  end

endmodule

// File: tb/tb_button_event.sv
// Testbench for button_event: PortWidth=2, HoldCycles=8, RepeatCycles=4, plus a
// single-channel RepeatCycles=1 instance.
module tb_button_event;

  localparam int unsigned W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [W-1:0] in;
  logic [W-1:0] press, rpt, evt, held, rel;

  logic r1_in;
  logic r1_press, r1_rpt, r1_evt, r1_held, r1_rel;

  int n_total = 0;
  int n_pass  = 0;

  button_event #(
    .PortWidth   (2),
    .HoldCycles  (8),
    .RepeatCycles(4)
  ) u_dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_in     (in),
    .o_press  (press),
    .o_repeat (rpt),
    .o_event  (evt),
    .o_held   (held)
`ifdef BUTTON_EVENT_RELEASE_EN
    ,
    .o_release(rel)
`endif
  );

  button_event #(
    .PortWidth   (1),
    .HoldCycles  (8),
    .RepeatCycles(1)
  ) u_dut_r1 (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_in     (r1_in),
    .o_press  (r1_press),
    .o_repeat (r1_rpt),
    .o_event  (r1_evt),
    .o_held   (r1_held)
`ifdef BUTTON_EVENT_RELEASE_EN
    ,
    .o_release(r1_rel)
`endif
  );

`ifndef BUTTON_EVENT_RELEASE_EN
  assign rel    = '0;
  assign r1_rel = 1'b0;
`endif

  typedef struct {
    string      name;
    logic [1:0] in;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Observed bundle: {press, repeat, event, held, release}.
  function automatic logic [9:0] obs();
    return {press, rpt, evt, held, rel};
  endfunction

  function automatic logic [4:0] obs1();
    return {r1_press, r1_rpt, r1_evt, r1_held, r1_rel};
  endfunction

  function automatic logic [1:0] rel_gate(logic [1:0] l);
`ifdef BUTTON_EVENT_RELEASE_EN
    return l;
`else
    return 2'b00;
`endif
  endfunction

  // Expected bundle; event is press | repeat.
  function automatic logic [9:0] pk(logic [1:0] p, logic [1:0] r, logic [1:0] h,
                                    logic [1:0] l);
    return {p, r, p | r, h, rel_gate(l)};
  endfunction

  // Expected {in, press, repeat, held, release} for a channel whose level rises
  // at edge s and stays high for len edges (Hold=8, Repeat=4).
  function automatic logic [4:0] ch_exp(int e, int s, int len);
    int d;
    d = e - s;
    if (d >= 0 && d < len)
      return {1'b1, d == 0, (d >= 8) && ((d - 8) % 4 == 0), 1'b1, 1'b0};
    else if (d == len)
      return 5'b00001;
    return 5'b00000;
  endfunction

  task automatic add_scenario(string tag, int s0, int len0, int s1, int len1, int edges);
    logic [4:0] c0, c1;
    vec_t v;
    for (int e = 0; e < edges; e++) begin
      c0 = ch_exp(e, s0, len0);
      c1 = ch_exp(e, s1, len1);
      v.name = $sformatf("%s_e%0d", tag, e);
      v.in   = {c1[4], c0[4]};
      v.exp  = pk({c1[3], c0[3]}, {c1[2], c0[2]}, {c1[1], c0[1]}, {c1[0], c0[0]});
      vecs.push_back(v);
    end
  endtask

  task automatic check(string name, logic [9:0] act, logic [9:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b (p,r,e,h,rel) required %b", name, act, exp);
  endtask

  task automatic edge_then_sample();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    in    = '0;
    r1_in = 1'b0;

    // Reset and async reset mid-operation.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", obs(), 10'b0);
    rst = 1'b0;
    in  = 2'b11;
    edge_then_sample();
    check("first_press", obs(), pk(2'b11, 2'b00, 2'b11, 2'b00));
    @(posedge clk);
    #2;
    check("held_before_rst", obs(), pk(2'b00, 2'b00, 2'b11, 2'b00));
    rst = 1'b1;
    #1;
    check("async_reset_clears", obs(), 10'b0);
    edge_then_sample();
    check("reset_held_in_high", obs(), 10'b0);
    rst = 1'b0;
    edge_then_sample();
    check("press_after_reset", obs(), pk(2'b11, 2'b00, 2'b11, 2'b00));
    edge_then_sample();
    check("press_one_cycle", obs(), pk(2'b00, 2'b00, 2'b11, 2'b00));
    in = 2'b00;
    edge_then_sample();
    check("release_after_reset", obs(), pk(2'b00, 2'b00, 2'b00, 2'b11));
    edge_then_sample();
    check("idle_after_release", obs(), 10'b0);

    // Table: short tap, long hold with channel 1 offset by 3, release race.
    add_scenario("tap", 0, 5, 1000, 0, 7);
    add_scenario("long", 0, 30, 3, 30, 36);
    add_scenario("race", 0, 8, 1000, 0, 10);
    foreach (vecs[i]) begin
      in = vecs[i].in;
      edge_then_sample();
      check(vecs[i].name, obs(), vecs[i].exp);
    end

    // RepeatCycles=1: repeat stays high every cycle from edge 8 until release.
    r1_in = 1'b1;
    for (int e = 0; e < 12; e++) begin
      logic p, r;
      edge_then_sample();
      p = (e == 0);
      r = (e >= 8);
      check($sformatf("r1_e%0d", e), {5'b0, obs1()}, {5'b0, p, r, p | r, 1'b1, 1'b0});
    end
    r1_in = 1'b0;
    edge_then_sample();
    check("r1_release", {5'b0, obs1()}, {5'b0, 4'b0000, rel_gate(2'b01) == 2'b01});
    edge_then_sample();
    check("r1_idle", {5'b0, obs1()}, 10'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/button_event.md
Name: button_event

Overview:
- Sits directly downstream of the per-button debouncer; consumes its clean, clk-synchronous level outputs.
- Converts each level into single-cycle event pulses for the register-file test controller:
  - a press pulse on each rising level;
  - auto-repeat pulses while the button stays held.
- Exposes a per-channel held level.
- Channels are fully independent; one FSM instance per channel.

Parameters:
- PortWidth, 1, number of button channels.
- HoldCycles, 50000000, cycles from press pulse to first repeat pulse; legal range >= 2.
- RepeatCycles, 10000000, cycles between successive repeat pulses; legal range >= 1.

Ports:
- clk  input  1  single system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- in  input  PortWidth  debounced button levels, 1 = pressed, already synchronous to clk.
- press  output  PortWidth  one-cycle pulse per channel on a press.
- repeat  output  PortWidth  one-cycle pulse per channel per auto-repeat tick.
- event  output  PortWidth  press | repeat, registered.
- held  output  PortWidth  1 while the channel FSM is not IDLE.

Behaviour:
- Clock and reset (fixed): one clock, clk; rst is asynchronous and active-high. While rst=1:
  - all outputs = 0;
  - all FSMs = IDLE;
  - all counters = 0;
  - prev level registers = 0.
- All outputs are registered. Latency: a level sampled at edge E affects outputs immediately after E (1 cycle).
- Per-channel FSM states: IDLE, HOLD, REPEAT. Per-channel counter width is clog2(max(HoldCycles, RepeatCycles)), minimum 1 bit.
- IDLE:
  - in=1 at edge E: go to HOLD, cnt<=0, press=1 for the cycle after E.
  - in=0: stay IDLE.
- HOLD, with in=1:
  - cnt==HoldCycles-1: repeat=1, go to REPEAT, cnt<=0.
  - Otherwise: cnt<=cnt+1.
  - Result: the first repeat pulse follows edge E+HoldCycles.
- REPEAT, with in=1:
  - cnt==RepeatCycles-1: repeat=1, cnt<=0.
  - Otherwise: cnt<=cnt+1.
  - Result: pulses follow edges E+HoldCycles+k*RepeatCycles, k>=1.
  - RepeatCycles=1: repeat stays high on every cycle in REPEAT.
- Any non-IDLE state, in=0 sampled: go to IDLE, cnt<=0, no press/repeat that cycle. A release on the same edge as a due repeat suppresses that repeat.
- press and repeat are never both 1 on the same channel in the same cycle.
- event = press | repeat, registered in the same stage (no extra latency).
- held = 1 in HOLD and REPEAT, registered alongside the state.
- Counters never wrap; they are cleared on every fire or release.
- Reset mid-operation: reset wins. If in is still 1 when rst deasserts, the first edge after reset produces a press pulse (prev resets to 0). This is intended.
- Out-of-range parameters (HoldCycles < 2 or RepeatCycles < 1): compile-time error via a generate-time check.

Optional Feature:
- Macro: BUTTON_EVENT_RELEASE_EN.
- Defined:
  - adds output port `release`, PortWidth wide;
  - `release` pulses for one cycle after the edge where a non-IDLE channel samples in=0;
  - reset value 0;
  - `release` is not ORed into event.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package button_event_pkg holds:
  - state encoding: IDLE=2'd0, HOLD=2'd1, REPEAT=2'd2 (2'd3 illegal, recovers to IDLE);
  - a function computing the counter width from HoldCycles and RepeatCycles.
- Natural sub-module: button_event_channel, the single-channel FSM plus counter.
- Top module generates PortWidth instances of button_event_channel and concatenates their outputs.

Test Plan (bench parameters PortWidth=2, HoldCycles=8, RepeatCycles=4):
- Reset check: assert rst asynchronously mid-cycle with in=2'b11 -> all outputs 0 immediately. Deassert rst -> press=2'b11 for exactly 1 cycle after the next edge, held=2'b11.
- Short tap: in[0] high for 5 edges -> press[0] 1 cycle after the first edge, repeat[0] never pulses, held[0] high 5 cycles then 0.
- Long hold: in[0] high from edge 0 for 30 edges -> press[0] after edge 0, repeat[0] after edges 8, 12, 16, 20, 24, 28, event[0] matches press|repeat.
- Release race: drop in[0] exactly at edge 8 -> no repeat pulse, held[0]=0 after edge 8. With BUTTON_EVENT_RELEASE_EN defined, release[0]=1 for that one cycle.
- Channel independence: in[1] rises 3 edges after in[0] -> channel 1 pulses are offset by exactly 3 cycles, with no cross-talk between channels.
- RepeatCycles=1 build: hold in[0] 12 edges -> repeat[0] continuously high from after edge 8 until release.
